// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller sharing one full-adder cell
//
// Purpose:
//   Adds two WIDTH-bit operands one bit per clock, LSB first, through a single
//   1-bit full adder (two half adders plus an OR). The operands live in
//   right-shifting registers and the running carry lives in one flop. Results
//   are returned with a start/done/ack handshake.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, adds port sub_i. Subtraction loads ~b_i and forces carry-in
//   to 1, giving a_i - b_i. In that case c_o=1 means no borrow.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_n_i   in   asynchronous active-low reset
//   start_i   in   request, accepted only while ready_o=1
//   a_i       in   operand A [WIDTH], sampled on accepted start
//   b_i       in   operand B [WIDTH], sampled on accepted start
//   c_i       in   carry-in, sampled on accepted start
//   sub_i     in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   ack_i     in   result acknowledge, honoured only in DONE
//   ready_o   out  high in IDLE
//   busy_o    out  high in SHIFT
//   done_o    out  high in DONE, result valid
//   s_o       out  sum [WIDTH]
//   c_o       out  carry-out
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  input  logic             ack_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  // Counter must hold WIDTH-1; keep at least one bit so WIDTH=1 stays legal.
  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  // Operand B and carry-in as they will be loaded on an accepted start.
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub_i ? ~b_i : b_i;
  assign c_load = sub_i ? 1'b1 : c_i;
`else
  assign b_load = b_i;
  assign c_load = c_i;
`endif

  // Shared full-adder cell built from two half adders and an OR.
  logic ha1_s, ha1_c, ha2_c;
  logic sum_bit, carry_nxt;

  assign ha1_s     = a_q[0] ^ b_q[0];
  assign ha1_c     = a_q[0] & b_q[0];
  assign sum_bit   = ha1_s ^ carry_q;
  assign ha2_c     = ha1_s & carry_q;
  assign carry_nxt = ha1_c | ha2_c;

  // New sum bit enters at the MSB while the register shifts right; the
  // concatenation form stays valid for WIDTH=1.
  logic [WIDTH:0] sum_cat;
  assign sum_cat = {sum_bit, sum_q};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_load;
            carry_q <= c_load;
            sum_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_nxt;
          sum_q   <= sum_cat[WIDTH:1];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (ack_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == SHIFT);
  assign done_o  = (state_q == DONE);
  assign s_o     = sum_q;
  assign c_o     = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         ack;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .c_i     (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i   (sub),
`endif
    .ack_i   (ack),
    .ready_o (ready),
    .busy_o  (busy),
    .done_o  (done),
    .s_o     (s),
    .c_o     (co)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for IDLE, present operands, hold start across one edge.
  task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(ready), 32'd1);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count busy cycles until done; a missed done within the bound is a failure.
  task automatic wait_done(input string nm, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) nbusy++;
    end
    check({nm, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  initial begin
    int nb;
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           tot;
    logic [W-1:0] es;
    logic         ec;

    rst_n = 1'b0; start = 1'b0; ack = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    tbl.push_back('{4'h3, 4'h5, 1'b0, 1'b0, 4'h8, 1'b0});
    tbl.push_back('{4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1});
    tbl.push_back('{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1});
    tbl.push_back('{4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0});
    tbl.push_back('{4'h0, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0});
    tbl.push_back('{4'hA, 4'h5, 1'b0, 1'b0, 4'hF, 1'b0});
    tbl.push_back('{4'h8, 4'h8, 1'b1, 1'b0, 4'h1, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    tbl.push_back('{4'h5, 4'h3, 1'b0, 1'b1, 4'h2, 1'b1});
    tbl.push_back('{4'h3, 4'h5, 1'b1, 1'b1, 4'hE, 1'b0});
`endif

    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_s",     32'(s),     32'd0);
    check("rst_c",     32'(co),    32'd0);
    rst_n = 1'b1;

    // Table vectors
    foreach (tbl[i]) begin
      do_start(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      wait_done($sformatf("vec%0d", i), nb);
      check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(W));
      check($sformatf("vec%0d_s", i), 32'(s), 32'(tbl[i].s));
      check($sformatf("vec%0d_c", i), 32'(co), 32'(tbl[i].co));
      do_ack();
      check($sformatf("vec%0d_ready_after_ack", i), 32'(ready), 32'd1);
    end

    // Result holds while ack stays low; start during SHIFT is ignored.
    do_start(4'h6, 4'h7, 1'b0, 1'b0);
    @(negedge clk);
    a = 4'h1; b = 4'h1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("shift_start", nb);
    check("shift_start_busy_rest", 32'(nb), 32'(W - 2));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_done", i), 32'(done), 32'd1);
      check($sformatf("hold%0d_s", i), 32'(s), 32'hD);
      check($sformatf("hold%0d_c", i), 32'(co), 32'd0);
    end

    // start and ack together in DONE: ack wins, start is dropped.
    @(negedge clk);
    ack = 1'b1; start = 1'b1; a = 4'h2; b = 4'h2; cin = 1'b0;
    @(posedge clk);
    #1 ack = 1'b0; start = 1'b0;
    check("both_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("both_still_idle", 32'(ready), 32'd1);
    check("idle_keeps_s", 32'(s), 32'hD);
    check("idle_keeps_c", 32'(co), 32'd0);

    // Load clears the sum register before any bit arrives.
    do_start(4'h9, 4'h9, 1'b0, 1'b0);
    check("load_clears_s", 32'(s), 32'd0);
    wait_done("after_clear", nb);
    check("after_clear_s", 32'(s), 32'h2);
    check("after_clear_c", 32'(co), 32'd1);
    do_ack();

    // Asynchronous reset during the second SHIFT cycle.
    do_start(4'h7, 4'h3, 1'b1, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_done",  32'(done),  32'd0);
    check("arst_s",     32'(s),     32'd0);
    check("arst_c",     32'(co),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(4'h2, 4'h2, 1'b0, 1'b0);
    wait_done("post_rst", nb);
    check("post_rst_s", 32'(s), 32'h4);
    check("post_rst_c", 32'(co), 32'd0);
    do_ack();

    // Randomized operations against an arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (rs) begin
        es = W'(int'(ra) - int'(rb));
        ec = (ra >= rb);
      end else begin
        tot = int'(ra) + int'(rb) + int'(rc);
        es  = W'(tot % (1 << W));
        ec  = (tot >= (1 << W));
      end
      do_start(ra, rb, rc, rs);
      wait_done($sformatf("rnd%0d", i), nb);
      check($sformatf("rnd%0d_busy_cycles", i), 32'(nb), 32'(W));
      check($sformatf("rnd%0d_s", i), 32'(s), 32'(es));
      check($sformatf("rnd%0d_c", i), 32'(co), 32'(ec));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check($sformatf("rnd%0d_s_stable", i), 32'(s), 32'(es));
      do_ack();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that shares one 1-bit full-adder cell (two half adders plus an OR gate) across all bits of a WIDTH-bit operand pair. It holds the operands in shift registers and the carry in a flop. It runs one bit per clock, LSB first, and returns the sum and carry-out with a start/done/ack handshake. It sits between a requesting unit and the adder datapath, and replaces a WIDTH-bit ripple adder when area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk_i  input  1  clock, rising-edge active
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  request; accepted only when ready_o=1
a_i  input  WIDTH  operand A, sampled on the accepted start
b_i  input  WIDTH  operand B, sampled on the accepted start
c_i  input  1  carry-in, sampled on the accepted start
ack_i  input  1  consumer acknowledge of the result; honoured only in DONE
ready_o  output  1  high in IDLE
busy_o  output  1  high in SHIFT
done_o  output  1  high in DONE; result valid
s_o  output  WIDTH  sum result
c_o  output  1  carry-out result

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset (rst_n_i=0, at any time, including mid-SHIFT or DONE):
  - state=IDLE.
  - Operand registers, sum register, carry flop and bit counter cleared to 0.
  - Outputs: ready_o=1, busy_o=0, done_o=0, s_o=0, c_o=0.
  - Any in-flight operation is discarded.
- State IDLE:
  - ready_o=1.
  - On a rising edge with start_i=1: load a_i, b_i into the shift registers, c_i into the carry flop, clear the counter, clear the sum register, go to SHIFT.
  - With start_i=0: stay in IDLE; all registers hold.
- State SHIFT, once per cycle:
  - sum bit = a[0]^b[0]^carry.
  - carry <= (a[0]&b[0]) | (carry&(a[0]^b[0])).
  - The sum bit shifts into the sum register at the MSB, and the register shifts right.
  - a and b shift right with zero fill.
  - The counter increments.
  - When the counter equals WIDTH-1 on that edge, go to DONE.
- Count: exactly WIDTH SHIFT cycles. With WIDTH=1, a single SHIFT cycle.
- Latency: if start is accepted at edge k, done_o rises after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles minimum, counting one IDLE cycle and one DONE cycle with ack_i=1.
- State DONE:
  - done_o=1.
  - s_o holds the full WIDTH-bit sum; c_o holds the final carry.
  - Both stay stable while ack_i=0.
  - On an edge with ack_i=1: go to IDLE.
- s_o and c_o after DONE: they keep their last values in IDLE and are overwritten only at the next load. Loading clears the sum register, so s_o reads 0 during SHIFT until bits arrive.
- start_i in SHIFT or DONE: ignored; there is no queueing.
- ack_i outside DONE: ignored.
- start_i and ack_i both high in DONE: ack is honoured and start is ignored. The new request must be re-presented in IDLE.
- Arithmetic: modulo 2^WIDTH; the carry-out appears on c_o.
- Outputs are registered or decoded directly from the state; there are no combinational paths from inputs to outputs.
- States are encoded in 2 bits. The unused encoding returns to IDLE on the next edge.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined: adds input port sub_i (1 bit), sampled with start_i.
  - When sub_i=1, the controller loads ~b_i into the B register and forces the carry flop to 1, ignoring c_i. The result is a_i - b_i.
  - c_o=1 means no borrow (a_i >= b_i).
  - When sub_i=0, behaviour is identical to addition.
- Undefined: port sub_i is absent and the block adds only.

Test Plan:
- Addition without carry-out: WIDTH=4, a_i=4'h3, b_i=4'h5, c_i=0, one-cycle start_i pulse -> busy_o high for 4 cycles, then done_o=1, s_o=4'h8, c_o=0.
- Wrap-around: a_i=4'hF, b_i=4'h1, c_i=0 -> s_o=4'h0, c_o=1.
- Carry-in propagation: a_i=4'hF, b_i=4'hF, c_i=1 -> s_o=4'hF, c_o=1.
- Handshake:
  - Hold ack_i=0 for 5 cycles after done_o -> done_o, s_o and c_o stay stable.
  - start_i pulsed during SHIFT with different operands -> ignored; the result still matches the first operands.
  - ack_i=1 -> ready_o=1 on the next cycle.
- Reset mid-operation: assert rst_n_i=0 asynchronously in the 2nd SHIFT cycle -> ready_o=1, busy_o=0, done_o=0, s_o=0, c_o=0 immediately, with no clock edge. A following start with 4'h2+4'h2 -> s_o=4'h4.
- With SERIAL_ADDER_SUB_EN defined:
  - sub_i=1, a_i=4'h5, b_i=4'h3 -> s_o=4'h2, c_o=1.
  - a_i=4'h3, b_i=4'h5 -> s_o=4'hE, c_o=0.
